// File: rtl/ras_ctrl.sv
// Return-address stack for fetch 1: push/pop/pop+push actions, TOS prediction
// target, per-branch checkpoint output and checkpoint restore on redirect.
module ras_ctrl #(
    parameter int DEPTH = 8,
    parameter int PW    = 3,
    parameter int AW    = 64
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          ras_vld_i,
    input  logic [1:0]    ras_ctl_i,
    input  logic [AW-1:0] push_addr_i,
    input  logic          stall_i,
    input  logic          recover_i,
    input  logic [PW-1:0] recover_ptr_i,
    input  logic [PW:0]   recover_cnt_i,
    input  logic [AW-1:0] recover_tos_i,
    output logic [AW-1:0] ras_data_o,
    output logic          ras_vld_o,
    output logic [PW-1:0] ckpt_ptr_o,
    output logic [PW:0]   ckpt_cnt_o,
    output logic [AW-1:0] ckpt_tos_o,
    output logic          ovf_o,
    output logic          unf_o
);

    localparam logic [1:0]  CTL_PUSH   = 2'b01;
    localparam logic [1:0]  CTL_POP    = 2'b10;
    localparam logic [1:0]  CTL_POPPSH = 2'b11;
    localparam logic [PW:0] CNT_FULL   = (PW+1)'(DEPTH);

    logic [AW-1:0] mem [DEPTH];
    logic [PW-1:0] ptr;
    logic [PW:0]   cnt;
    logic          ovf;
    logic          unf;

    logic          act;
    logic [PW-1:0] ptr_inc;
    logic [PW-1:0] ptr_dec;
    logic          empty;
    logic          full;

    assign act     = ras_vld_i & ~stall_i & ~recover_i;
    assign ptr_inc = ptr + PW'(1);
    assign ptr_dec = ptr - PW'(1);
    assign empty   = (cnt == '0);
    assign full    = (cnt == CNT_FULL);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr <= '0;
            cnt <= '0;
            ovf <= 1'b0;
            unf <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            ovf <= 1'b0;
            unf <= 1'b0;
            if (recover_i) begin
                // restore wins over any action presented in the same cycle
                ptr                <= recover_ptr_i;
                cnt                <= recover_cnt_i;
                mem[recover_ptr_i] <= recover_tos_i;
            end else if (act) begin
                case (ras_ctl_i)
                    CTL_PUSH: begin
                        ptr          <= ptr_inc;
                        mem[ptr_inc] <= push_addr_i;
                        // when full the wrap overwrites the oldest entry
                        if (full) begin
                            ovf <= 1'b1;
                        end else begin
                            cnt <= cnt + (PW+1)'(1);
                        end
                    end
                    CTL_POP: begin
                        if (empty) begin
                            unf <= 1'b1;
                        end else begin
                            ptr <= ptr_dec;
                            cnt <= cnt - (PW+1)'(1);
                        end
                    end
                    CTL_POPPSH: begin
                        mem[ptr] <= push_addr_i;
                        if (empty) begin
                            cnt <= (PW+1)'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign ras_data_o = mem[ptr];
    assign ras_vld_o  = ~empty;
    assign ckpt_ptr_o = ptr;
    assign ckpt_cnt_o = cnt;
    assign ckpt_tos_o = mem[ptr];
    assign ovf_o      = ovf;
    assign unf_o      = unf;

endmodule

// File: tb/tb_ras_ctrl.sv
// Scoreboard bench for ras_ctrl: directed scenarios plus random traffic
// checked against a behavioural stack model.
module tb_ras_ctrl;

    localparam int DEPTH = 8;
    localparam int PW    = 3;
    localparam int AW    = 64;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          ras_vld_i = 1'b0;
    logic [1:0]    ras_ctl_i = 2'b00;
    logic [AW-1:0] push_addr_i = '0;
    logic          stall_i = 1'b0;
    logic          recover_i = 1'b0;
    logic [PW-1:0] recover_ptr_i = '0;
    logic [PW:0]   recover_cnt_i = '0;
    logic [AW-1:0] recover_tos_i = '0;
    logic [AW-1:0] ras_data_o;
    logic          ras_vld_o;
    logic [PW-1:0] ckpt_ptr_o;
    logic [PW:0]   ckpt_cnt_o;
    logic [AW-1:0] ckpt_tos_o;
    logic          ovf_o;
    logic          unf_o;

    ras_ctrl #(.DEPTH(DEPTH), .PW(PW), .AW(AW)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .ras_vld_i(ras_vld_i), .ras_ctl_i(ras_ctl_i), .push_addr_i(push_addr_i),
        .stall_i(stall_i), .recover_i(recover_i),
        .recover_ptr_i(recover_ptr_i), .recover_cnt_i(recover_cnt_i),
        .recover_tos_i(recover_tos_i),
        .ras_data_o(ras_data_o), .ras_vld_o(ras_vld_o),
        .ckpt_ptr_o(ckpt_ptr_o), .ckpt_cnt_o(ckpt_cnt_o), .ckpt_tos_o(ckpt_tos_o),
        .ovf_o(ovf_o), .unf_o(unf_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [AW-1:0] data;
        logic          vld;
        int            ptr;
        int            cnt;
        logic          ovf;
        logic          unf;
    } exp_t;

    typedef struct {
        int            ptr;
        int            cnt;
        logic [AW-1:0] tos;
    } ckpt_t;

    exp_t  exp_q[$];
    ckpt_t hist_q[$];
    int    checks = 0;
    int    errors = 0;
    bit    done = 0;

    // Model: circular storage, integer pointer and occupancy, flags from the last action.
    logic [AW-1:0] m_mem [DEPTH];
    int            m_ptr, m_cnt;
    logic          m_ovf, m_unf;

    function automatic void model_reset();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        m_ptr = 0; m_cnt = 0; m_ovf = 0; m_unf = 0;
    endfunction

    function automatic void model_step(bit v, bit [1:0] c, logic [AW-1:0] a, bit s,
                                       bit r, int rp, int rc, logic [AW-1:0] rt);
        m_ovf = 0;
        m_unf = 0;
        if (r) begin
            m_ptr = rp; m_cnt = rc; m_mem[rp] = rt;
        end else if (v && !s) begin
            if (c == 2'd1) begin
                m_ptr = (m_ptr + 1) % DEPTH;
                m_mem[m_ptr] = a;
                if (m_cnt < DEPTH) m_cnt++; else m_ovf = 1;
            end else if (c == 2'd2) begin
                if (m_cnt > 0) begin
                    m_ptr = (m_ptr + DEPTH - 1) % DEPTH;
                    m_cnt--;
                end else m_unf = 1;
            end else if (c == 2'd3) begin
                m_mem[m_ptr] = a;
                if (m_cnt == 0) m_cnt = 1;
            end
        end
    endfunction

    function automatic exp_t model_view();
        exp_t e;
        e.data = m_mem[m_ptr];
        e.vld  = (m_cnt != 0);
        e.ptr  = m_ptr;
        e.cnt  = m_cnt;
        e.ovf  = m_ovf;
        e.unf  = m_unf;
        return e;
    endfunction

    function automatic void check(string name, logic [AW-1:0] act, logic [AW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endfunction

    task automatic step(bit v, bit [1:0] c, logic [AW-1:0] a, bit s = 0,
                        bit r = 0, int rp = 0, int rc = 0, logic [AW-1:0] rt = '0);
        @(negedge clk_i);
        ras_vld_i = v; ras_ctl_i = c; push_addr_i = a; stall_i = s;
        recover_i = r; recover_ptr_i = PW'(rp); recover_cnt_i = (PW+1)'(rc);
        recover_tos_i = rt;
        @(posedge clk_i);
        hist_q.push_back('{m_ptr, m_cnt, m_mem[m_ptr]});
        if (hist_q.size() > 16) void'(hist_q.pop_front());
        model_step(v, c, a, s, r, rp, rc, rt);
        exp_q.push_back(model_view());
    endtask

    task automatic idle();
        step(0, 2'd0, '0);
    endtask

    task automatic check_reset_outputs(string tag);
        check({tag, "_data"}, ras_data_o, '0);
        check({tag, "_vld"},  AW'(ras_vld_o), '0);
        check({tag, "_ptr"},  AW'(ckpt_ptr_o), '0);
        check({tag, "_cnt"},  AW'(ckpt_cnt_o), '0);
        check({tag, "_ovf"},  AW'(ovf_o), '0);
        check({tag, "_unf"},  AW'(unf_o), '0);
    endtask

    // Monitor: the DUT presents a new state after every clock edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk_i);
            #1;
            if (done) break;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("ras_data", ras_data_o, e.data);
                check("ras_vld",  AW'(ras_vld_o), AW'(e.vld));
                check("ckpt_ptr", AW'(ckpt_ptr_o), AW'(e.ptr));
                check("ckpt_cnt", AW'(ckpt_cnt_o), AW'(e.cnt));
                check("ckpt_tos", ckpt_tos_o, e.data);
                check("ovf",      AW'(ovf_o), AW'(e.ovf));
                check("unf",      AW'(unf_o), AW'(e.unf));
            end
        end
    end

    initial begin
        ckpt_t ck;
        model_reset();
        #1;
        check_reset_outputs("reset");
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        idle();

        // basic push/pop
        step(1, 2'd1, 64'h1000);
        step(1, 2'd1, 64'h2000);
        step(1, 2'd2, '0);
        step(1, 2'd2, '0);
        // pop on empty
        step(1, 2'd2, '0);
        idle();
        // overflow with nine pushes, then drain past empty
        for (int i = 0; i < 9; i++) step(1, 2'd1, 64'hA0 + 64'(i));
        for (int i = 0; i < 9; i++) step(1, 2'd2, '0);
        idle();
        // checkpoint and restore
        step(1, 2'd1, 64'h100);
        ck = '{m_ptr, m_cnt, m_mem[m_ptr]};
        step(1, 2'd2, '0);
        step(1, 2'd3, 64'h300);
        step(1, 2'd1, 64'h400);
        step(0, 2'd0, '0, 0, 1, ck.ptr, ck.cnt, ck.tos);
        // recovery beats a same-cycle push; stall blocks a push
        step(1, 2'd1, 64'h777, 0, 1, 5, 3, 64'h555);
        step(1, 2'd1, 64'h888, 1);
        // drain, then pop+push on empty
        for (int i = 0; i < 4; i++) step(1, 2'd2, '0);
        step(1, 2'd3, 64'h500);
        idle();

        for (int n = 0; n < 3000; n++) begin
            bit v, s, r;
            bit [1:0] c;
            logic [AW-1:0] a;
            int rp, rc;
            logic [AW-1:0] rt;
            v = ($urandom_range(0, 99) < 85);
            s = ($urandom_range(0, 99) < 10);
            r = ($urandom_range(0, 99) < 5);
            c = 2'($urandom_range(0, 3));
            a = {$urandom, $urandom};
            if (hist_q.size() > 0 && $urandom_range(0, 1) == 1) begin
                ck = hist_q[$urandom_range(0, hist_q.size() - 1)];
                rp = ck.ptr; rc = ck.cnt; rt = ck.tos;
            end else begin
                rp = $urandom_range(0, DEPTH - 1);
                rc = $urandom_range(0, DEPTH);
                rt = {$urandom, $urandom};
            end
            step(v, c, a, s, r, rp, rc, rt);
        end

        // async reset in the middle of a recovery
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        recover_i = 1'b1; recover_ptr_i = 3'd4; recover_cnt_i = 4'd5;
        recover_tos_i = 64'hDEAD;
        ras_vld_i = 1'b1; ras_ctl_i = 2'd1;
        #1;
        rst_i = 1'b1;
        #1;
        check_reset_outputs("midreset");
        model_reset();
        @(negedge clk_i);
        rst_i = 1'b0;
        recover_i = 1'b0; ras_vld_i = 1'b0; ras_ctl_i = 2'd0;
        idle();
        step(1, 2'd1, 64'hBEEF);
        idle();

        repeat (3) @(posedge clk_i);
        #2;
        done = 1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
